// File: rtl/alu_64_pkg.sv
// alu_64 shared definitions: opcode enum and widths.
// No ports; imported by RTL and benches.
package alu_64_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    LOAD = 3'd0,
    SUM  = 3'd1,
    SUB  = 3'd2,
    AND  = 3'd3,
    XOR  = 3'd4,
    NOT  = 3'd5,
    INC  = 3'd6
  } alu_op_t;

endpackage

// File: rtl/alu_64_if.sv
// alu_64 operand/result bundle.
// master: drives opcode, a, b; slave: drives result and flags.
interface alu_64_if
  import alu_64_pkg::*;
#(
  parameter int WIDTH = 64
);

  logic [OP_W-1:0]  opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             negative;
  logic             zero;
  logic             equal;
  logic             greater;
  logic             less;

  modport master (
    output opcode, a, b,
    input  result, overflow, negative,
    input  zero, equal, greater, less
  );

  modport slave (
    input  opcode, a, b,
    output result, overflow, negative,
    output zero, equal, greater, less
  );

endinterface

// File: rtl/alu_64_adder.sv
// Shared add/sub/inc path with signed overflow.
// i_a, i_b, i_cin, i_sub -> o_sum, o_ovf (all combinational).
module alu_64_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;

  // subtract is a + ~b + 1; caller supplies the +1 as carry-in
  assign w_b   = i_sub ? ~i_b : i_b;
  assign o_sum = i_a + w_b + {{(WIDTH-1){1'b0}}, i_cin};

  // operands of one sign producing the other sign
  assign o_ovf = (i_a[WIDTH-1] == w_b[WIDTH-1]) &&
                 (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu_64.sv
// Single-cycle registered ALU: one op accepted per clock.
// clk, reset (sync, active-high), bus (alu_64_if.slave).
module alu_64
  import alu_64_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  alu_64_if.slave  bus
);

  logic [WIDTH-1:0] w_add_b;
  logic             w_cin;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;

  logic [WIDTH-1:0] r_result;
  logic             r_overflow;
  logic             r_negative;
  logic             r_zero;
  logic             r_equal;
  logic             r_greater;
  logic             r_less;

  // INC reuses the adder as a + 0 + carry-in
  assign w_add_b = (bus.opcode == INC) ? '0 : bus.b;
  assign w_sub   = (bus.opcode == SUB);
  assign w_cin   = (bus.opcode == SUB) ||
                   (bus.opcode == INC);

  alu_64_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a   (bus.a),
    .i_b   (w_add_b),
    .i_cin (w_cin),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    unique case (bus.opcode)
      LOAD: w_res = bus.a;
      SUM: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      SUB: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      AND: w_res = bus.a & bus.b;
      XOR: w_res = bus.a ^ bus.b;
      NOT: w_res = ~bus.a;
      INC: begin
        w_res = w_sum;
        w_ovf = w_add_ovf;
      end
      default: w_res = '0;
    endcase
  end

  // comparisons look only at the operands, never the op
  assign w_eq = (bus.a == bus.b);
  assign w_gt = ($signed(bus.a) > $signed(bus.b));
  assign w_lt = ($signed(bus.a) < $signed(bus.b));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_negative <= 1'b0;
      r_zero     <= 1'b0;
      r_equal    <= 1'b0;
      r_greater  <= 1'b0;
      r_less     <= 1'b0;
    end else begin
      r_result   <= w_res;
      r_overflow <= w_ovf;
      r_negative <= w_res[WIDTH-1];
      r_zero     <= (w_res == '0);
      r_equal    <= w_eq;
      r_greater  <= w_gt;
      r_less     <= w_lt;
    end
  end

  assign bus.result   = r_result;
  assign bus.overflow = r_overflow;
  assign bus.negative = r_negative;
  assign bus.zero     = r_zero;
  assign bus.equal    = r_equal;
  assign bus.greater  = r_greater;
  assign bus.less     = r_less;

endmodule

// File: tb/tb_alu_64.sv
// Directed vector bench for alu_64.
// Flags packed as {ovf, neg, zero, eq, gt, lt}.
module tb_alu_64;
  import alu_64_pkg::*;

  localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [5:0]  flg;
  } vec_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  vec_t vecs[18];

  alu_64_if #(.WIDTH(64)) bus ();

  alu_64 #(.WIDTH(64)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {bus.overflow, bus.negative, bus.zero,
            bus.equal, bus.greater, bus.less};
  endfunction

  task automatic drive(input logic [2:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b);
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string nm,
                         input logic [63:0] exp);
    n_chk++;
    if (bus.result !== exp) begin
      n_fail++;
      $display("FAIL %s result got %h want %h",
               nm, bus.result, exp);
    end
  endtask

  task automatic chk_flg(input string nm,
                         input logic [5:0] exp);
    n_chk++;
    if (flags() !== exp) begin
      n_fail++;
      $display("FAIL %s flags got %b want %b",
               nm, flags(), exp);
    end
  endtask

  task automatic chk_one(input string nm);
    n_chk++;
    if ($countones({bus.equal, bus.greater,
                    bus.less}) != 1) begin
      n_fail++;
      $display("FAIL %s cmp-onehot got %b want one",
               nm, {bus.equal, bus.greater, bus.less});
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    //          op    a       b       result                    flags
    vecs[0]  = '{SUM,  64'd12, 64'd25, 64'd37,                  6'b000001};
    vecs[1]  = '{SUB,  64'd12, 64'd25, 64'hFFFF_FFFF_FFFF_FFF3, 6'b010001};
    vecs[2]  = '{AND,  64'd12, 64'd25, 64'd8,                   6'b000001};
    vecs[3]  = '{XOR,  64'd12, 64'd25, 64'd21,                  6'b000001};
    vecs[4]  = '{NOT,  64'd0,  64'd0,  NEG1,                    6'b010100};
    vecs[5]  = '{INC,  64'd2,  64'd0,  64'd3,                   6'b000010};
    vecs[6]  = '{SUM,  MAXV,   64'd3,  64'h8000_0000_0000_0002, 6'b110010};
    vecs[7]  = '{SUB,  MINV,   64'd3,  64'h7FFF_FFFF_FFFF_FFFD, 6'b100001};
    vecs[8]  = '{SUB,  64'd54, 64'd54, 64'd0,                   6'b001100};
    vecs[9]  = '{INC,  MAXV,   64'd0,  MINV,                    6'b110010};
    vecs[10] = '{INC,  NEG1,   64'd5,  64'd0,                   6'b001001};
    vecs[11] = '{LOAD, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100,
                 64'hFFFF_FFFF_FFFF_FFF9,                       6'b010001};
    vecs[12] = '{3'd7, 64'd3,  64'd3,  64'd0,                   6'b001100};
    vecs[13] = '{SUM,  NEG1,   NEG1,   64'hFFFF_FFFF_FFFF_FFFE, 6'b010100};
    vecs[14] = '{SUM,  MINV,   MINV,   64'd0,                   6'b101100};
    vecs[15] = '{SUB,  64'd0,  MINV,   MINV,                    6'b110010};
    vecs[16] = '{NOT,  MAXV,   MAXV,   MINV,                    6'b010100};
    vecs[17] = '{XOR,  64'hFF00, 64'h0F0F, 64'hF00F,            6'b000010};

    reset = 1'b1;
    drive(SUM, MAXV, 64'd3);
    tick();
    tick();
    chk_res("reset0", 64'd0);
    chk_flg("reset0", 6'b000000);

    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      chk_res($sformatf("vec%0d", i), vecs[i].res);
      chk_flg($sformatf("vec%0d", i), vecs[i].flg);
      chk_one($sformatf("vec%0d", i));
    end

    // back-to-back ops: each result follows its own edge
    drive(SUM, 64'd1, 64'd1);
    tick();
    drive(SUB, 64'd1, 64'd1);
    chk_res("b2b0", 64'd2);
    tick();
    chk_res("b2b1", 64'd0);
    chk_flg("b2b1", 6'b001100);

    // reset mid-stream with a live op presented
    drive(SUM, 64'd12, 64'd25);
    tick();
    chk_res("pre_rst", 64'd37);
    reset = 1'b1;
    drive(SUM, MAXV, 64'd3);
    tick();
    chk_res("mid_rst", 64'd0);
    chk_flg("mid_rst", 6'b000000);
    drive(INC, 64'd9, 64'd9);
    tick();
    chk_res("hold_rst", 64'd0);
    chk_flg("hold_rst", 6'b000000);

    reset = 1'b0;
    drive(LOAD, 64'd5, 64'd2);
    tick();
    chk_res("post_rst", 64'd5);
    chk_flg("post_rst", 6'b000010);
    drive(LOAD, 64'd0, 64'd0);
    tick();
    chk_res("post_rst2", 64'd0);
    chk_flg("post_rst2", 6'b001100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_64.md
ALU_64 -- requirements
Module: alu_64

Interface
REQ-001 SHALL have parameter: WIDTH, default 64, operand/result width; all widths below are stated for the default.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: opcode  input  3  operation select (encoding per REQ-013).
REQ-005 SHALL have port: a  input  64  signed operand A (two's complement).
REQ-006 SHALL have port: b  input  64  signed operand B (two's complement).
REQ-007 SHALL have port: result  output  64  registered signed result.
REQ-008 SHALL have port: overflow  output  1  registered signed-overflow flag.
REQ-009 SHALL have port: negative  output  1  registered flag, result MSB.
REQ-010 SHALL have port: zero  output  1  registered flag, result == 0.
REQ-011 SHALL have ports: equal, greater, less  output  1 each  registered signed comparison of a against b.

Function
REQ-012 SHALL sample opcode, a and b on every rising clk edge with reset low, and present the result and all flags registered after exactly one cycle; no handshake, a new operation is accepted every cycle.
REQ-013 SHALL decode opcode as: 0 LOAD result=a; 1 SUM a+b; 2 SUB a-b; 3 AND a&b; 4 XOR a^b; 5 NOT ~a; 6 INC a+1; 7 reserved, result=0.
REQ-014 SHALL ignore b for LOAD, NOT and INC.
REQ-015 SHALL perform arithmetic modulo 2^64 (wrap-around) with the result truncated to 64 bits.
REQ-016 SHALL set overflow for SUM when a and b have equal signs and the result sign differs.
REQ-017 SHALL set overflow for SUB when a and b have different signs and the result sign differs from a.
REQ-018 SHALL set overflow for INC only when a = 0x7FFF_FFFF_FFFF_FFFF.
REQ-019 SHALL clear overflow for LOAD, AND, XOR, NOT and reserved opcodes.
REQ-020 SHALL set negative = result[63] and zero = (result == 0) from the same-cycle result, for every opcode.
REQ-021 SHALL compute equal (a==b), greater (a>b) and less (a<b) as signed comparisons for every opcode, independent of the selected operation; exactly one of the three SHALL be 1 outside reset.
REQ-022 SHALL never make the comparison flags depend on overflow; e.g. a=MIN, b=3 gives less=1.

Reset
REQ-023 SHALL clear result and every flag (including zero and equal) to 0 on the rising clk edge with reset high.
REQ-024 SHALL give reset priority over any operation; an operation presented while reset is high is discarded.
REQ-025 SHALL produce valid outputs for the operation sampled on the first rising edge after reset deasserts, one cycle later.

Structure
REQ-026 SHALL take opcode constants from a shared package alu_64_pkg (3-bit enumerated type alu_op_t: LOAD, SUM, SUB, AND, XOR, NOT, INC), also imported by benches.
REQ-027 SHALL implement the add/subtract/increment path as one sub-module alu_64_adder (a, b, carry-in, subtract select -> sum, signed overflow), shared by SUM, SUB and INC.
REQ-028 SHALL keep all datapath logic combinational, with a single output register stage in alu_64.

Verification
REQ-029 SHALL verify SUM a=12 b=25 -> result 37, all flags 0 except less=1; SUB a=12 b=25 -> result -13, negative=1, less=1.
REQ-030 SHALL verify AND a=12 b=25 -> 8; XOR a=12 b=25 -> 21; both with overflow=0 and less=1.
REQ-031 SHALL verify NOT a=0 -> result -1, negative=1; INC a=2 -> 3, overflow=0.
REQ-032 SHALL verify SUM a=0x7FFF_FFFF_FFFF_FFFF b=3 -> 0x8000_0000_0000_0002 with overflow=1, negative=1, greater=1; SUB a=0x8000_0000_0000_0000 b=3 -> 0x7FFF_FFFF_FFFF_FFFD with overflow=1, negative=0, less=1.
REQ-033 SHALL verify SUB a=54 b=54 -> result 0, zero=1, equal=1, overflow=0.
REQ-034 SHALL verify reset asserted mid-stream clears result and all flags to 0 on the next edge, and that a LOAD a=5 presented on the first edge after release gives result 5 one cycle later.
